// File: rtl/bsg_clk_gen_pearl_tag_driver_pkg.sv
// Shared types and helpers for the serial bsg_tag driver feeding the clock-generator pearl.
// The header field order on the wire is start, len, data_not_reset, node id, then payload.
package bsg_clk_gen_pearl_tag_driver_pkg;

   typedef enum logic [3:0] {
      IDLE,
      INIT1,
      INIT0,
      START,
      LEN,
      DNR,
      NODE,
      PAY,
      GAP
   } tag_state_e;

   localparam int TAG_START_BITS = 1;
   localparam int TAG_DNR_BITS   = 1;

   function automatic int tag_packet_bits(input int els, input int lg_width, input int len);
      return TAG_START_BITS + lg_width + TAG_DNR_BITS + $clog2(els) + len;
   endfunction

   function automatic int tag_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bsg_clk_gen_pearl_tag_driver_shifter.sv
// Loadable LSB-first shift register with a companion down-counter of bits left in the field.
// The current wire bit is data_q[0]; next_bit_o looks one bit ahead so the caller can register it.
module bsg_clk_gen_pearl_tag_driver_shifter #(
   parameter int data_width_p = 15,
   parameter int cnt_width_p  = 7
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    load_i,
   input  logic [data_width_p-1:0] load_data_i,
   input  logic [cnt_width_p-1:0]  load_cnt_i,
   input  logic                    shift_i,
   output logic                    next_bit_o,
   output logic                    last_o
);

   logic [data_width_p-1:0] data_q;
   logic [data_width_p-1:0] data_shifted;
   logic [cnt_width_p-1:0]  cnt_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else if (load_i) begin
         data_q <= load_data_i;
         cnt_q  <= load_cnt_i;
      end else if (shift_i) begin
         data_q <= data_shifted;
         cnt_q  <= cnt_q - cnt_width_p'(1);
      end
   end

   assign data_shifted = data_q >> 1;
   assign next_bit_o   = data_shifted[0];
   assign last_o       = (cnt_q == cnt_width_p'(1));

endmodule

// File: rtl/bsg_clk_gen_pearl_tag_driver.sv
// Serial bsg_tag transmitter: emits either the tag-network init sequence or one framed
// packet, LSB-first, one bit per clk_i; state_q always names the field of the bit on the wire.
module bsg_clk_gen_pearl_tag_driver
   import bsg_clk_gen_pearl_tag_driver_pkg::*;
#(
   parameter int tag_els_p      = 16,
   parameter int tag_lg_width_p = 4,
   parameter int init_ones_p    = 64,
   parameter int init_zeros_p   = 16,
   localparam int lg_els_lp        = $clog2(tag_els_p),
   localparam int payload_width_lp = (2 ** tag_lg_width_p) - 1
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        v_i,
   output logic                        ready_o,
   input  logic                        init_i,
   input  logic [lg_els_lp-1:0]        node_id_i,
   input  logic                        data_not_reset_i,
   input  logic [tag_lg_width_p-1:0]   len_i,
   input  logic [payload_width_lp-1:0] payload_i,
   output logic                        tag_data_o,
   output logic                        done_o
);

   localparam int cnt_width_lp  = $clog2(tag_max3(init_ones_p, init_zeros_p, 2 ** tag_lg_width_p)) + 1;
   localparam int data_width_lp = tag_max3(payload_width_lp, tag_lg_width_p, lg_els_lp);

   tag_state_e                  state_q, state_d;
   logic                        tag_data_q, tag_data_d;
   logic                        ready_q;
   logic                        accept;
   logic [lg_els_lp-1:0]        node_q;
   logic                        dnr_q;
   logic [tag_lg_width_p-1:0]   len_q;
   logic [payload_width_lp-1:0] payload_q;

   logic                        sh_load, sh_shift, sh_next_bit, sh_last;
   logic [data_width_lp-1:0]    sh_load_data;
   logic [cnt_width_lp-1:0]     sh_load_cnt;

   assign accept = v_i & ready_q;

   // ready is registered so it stays low through reset and rises on the first edge after release.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE;
         tag_data_q <= 1'b0;
         ready_q    <= 1'b0;
         node_q     <= '0;
         dnr_q      <= 1'b0;
         len_q      <= '0;
         payload_q  <= '0;
      end else begin
         state_q    <= state_d;
         tag_data_q <= tag_data_d;
         ready_q    <= (state_d == IDLE);
         if (accept) begin
            node_q    <= node_id_i;
            dnr_q     <= data_not_reset_i;
            len_q     <= len_i;
            payload_q <= payload_i;
         end
      end
   end

   // Each transition also picks the first bit of the next field so tag_data_o stays a flop.
   always_comb begin
      state_d      = state_q;
      tag_data_d   = 1'b0;
      sh_load      = 1'b0;
      sh_shift     = 1'b0;
      sh_load_data = '0;
      sh_load_cnt  = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sh_load    = 1'b1;
               tag_data_d = 1'b1;
               if (init_i) begin
                  state_d     = INIT1;
                  sh_load_cnt = cnt_width_lp'(init_ones_p);
               end else begin
                  state_d     = START;
                  sh_load_cnt = cnt_width_lp'(1);
               end
            end
         end
         INIT1: begin
            if (sh_last) begin
               state_d     = INIT0;
               sh_load     = 1'b1;
               sh_load_cnt = cnt_width_lp'(init_zeros_p);
            end else begin
               sh_shift   = 1'b1;
               tag_data_d = 1'b1;
            end
         end
         INIT0: begin
            if (sh_last) begin
               state_d = IDLE;
               sh_load = 1'b1;
            end else begin
               sh_shift = 1'b1;
            end
         end
         START: begin
            state_d      = LEN;
            sh_load      = 1'b1;
            sh_load_data = data_width_lp'(len_q);
            sh_load_cnt  = cnt_width_lp'(tag_lg_width_p);
            tag_data_d   = len_q[0];
         end
         LEN: begin
            if (sh_last) begin
               state_d     = DNR;
               sh_load     = 1'b1;
               sh_load_cnt = cnt_width_lp'(1);
               tag_data_d  = dnr_q;
            end else begin
               sh_shift   = 1'b1;
               tag_data_d = sh_next_bit;
            end
         end
         DNR: begin
            state_d      = NODE;
            sh_load      = 1'b1;
            sh_load_data = data_width_lp'(node_q);
            sh_load_cnt  = cnt_width_lp'(lg_els_lp);
            tag_data_d   = node_q[0];
         end
         NODE: begin
            if (sh_last) begin
               sh_load = 1'b1;
               if (len_q != '0) begin
                  state_d      = PAY;
                  sh_load_data = data_width_lp'(payload_q);
                  sh_load_cnt  = cnt_width_lp'(len_q);
                  tag_data_d   = payload_q[0];
               end else begin
                  state_d     = GAP;
                  sh_load_cnt = cnt_width_lp'(1);
               end
            end else begin
               sh_shift   = 1'b1;
               tag_data_d = sh_next_bit;
            end
         end
         PAY: begin
            if (sh_last) begin
               state_d     = GAP;
               sh_load     = 1'b1;
               sh_load_cnt = cnt_width_lp'(1);
            end else begin
               sh_shift   = 1'b1;
               tag_data_d = sh_next_bit;
            end
         end
         GAP: begin
            state_d = IDLE;
            sh_load = 1'b1;
         end
         default: begin
            state_d = IDLE;
            sh_load = 1'b1;
         end
      endcase
   end

   bsg_clk_gen_pearl_tag_driver_shifter #(
      .data_width_p(data_width_lp),
      .cnt_width_p (cnt_width_lp)
   ) shifter (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .load_i     (sh_load),
      .load_data_i(sh_load_data),
      .load_cnt_i (sh_load_cnt),
      .shift_i    (sh_shift),
      .next_bit_o (sh_next_bit),
      .last_o     (sh_last)
   );

   assign ready_o    = ready_q;
   assign tag_data_o = tag_data_q;
   assign done_o     = sh_last & ((state_q == INIT0) | (state_q == PAY) |
                                  ((state_q == NODE) & (len_q == '0)));

endmodule

// File: tb/tb_bsg_clk_gen_pearl_tag_driver.sv
// Directed bench for the bsg_tag serial driver, with a small tag-master receiver model
// that decodes the wire independently to confirm packets after re-initialisation.
module tb_bsg_clk_gen_pearl_tag_driver;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        v_i;
   logic        ready_o;
   logic        init_i;
   logic [3:0]  node_id_i;
   logic        data_not_reset_i;
   logic [3:0]  len_i;
   logic [14:0] payload_i;
   logic        tag_data_o;
   logic        done_o;

   int compared = 0;
   int mismatched = 0;
   bit expBits[$];

   int          rxOnes = 0;
   bit          rxInit = 1'b0;
   int          rxPos = -1;
   logic [3:0]  rxLen = '0;
   logic        rxDnr = 1'b0;
   logic [3:0]  rxNode = '0;
   logic [14:0] rxPay = '0;
   int          rxPackets = 0;
   int          rxBefore;

   bsg_clk_gen_pearl_tag_driver dut (
      .clk_i           (clk_i),
      .reset_n_i       (reset_n_i),
      .v_i             (v_i),
      .ready_o         (ready_o),
      .init_i          (init_i),
      .node_id_i       (node_id_i),
      .data_not_reset_i(data_not_reset_i),
      .len_i           (len_i),
      .payload_i       (payload_i),
      .tag_data_o      (tag_data_o),
      .done_o          (done_o)
   );

   always #5 clk_i = ~clk_i;

   // Receiver model: a long run of ones initialises it, then it frames start/len/dnr/node/payload.
   always @(posedge clk_i) begin
      int ones;
      ones = tag_data_o ? rxOnes + 1 : 0;
      rxOnes <= ones;
      if (ones >= 32) begin
         rxInit <= 1'b1;
         rxPos  <= -1;
      end else if (rxInit) begin
         if (rxPos == -1) begin
            if (!tag_data_o) rxPos <= 0;
         end else if (rxPos == 0) begin
            if (tag_data_o) begin
               rxPos <= 1;
               rxPay <= '0;
            end
         end else begin
            if (rxPos <= 4) rxLen[rxPos-1] <= tag_data_o;
            else if (rxPos == 5) rxDnr <= tag_data_o;
            else if (rxPos <= 9) rxNode[rxPos-6] <= tag_data_o;
            else rxPay[rxPos-10] <= tag_data_o;
            if (rxPos >= 9 && rxPos == 9 + int'(rxLen)) begin
               rxPackets <= rxPackets + 1;
               rxPos     <= -1;
            end else begin
               rxPos <= rxPos + 1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic init, input logic [3:0] node,
                                input logic dnr, input logic [3:0] len, input logic [14:0] pay);
      v_i              = v;
      init_i           = init;
      node_id_i        = node;
      data_not_reset_i = dnr;
      len_i            = len;
      payload_i        = pay;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic buildBits(input logic [3:0] len, input logic dnr, input logic [3:0] node,
                            input logic [14:0] pay);
      expBits.delete();
      expBits.push_back(1'b1);
      for (int i = 0; i < 4; i++) expBits.push_back(len[i]);
      expBits.push_back(dnr);
      for (int i = 0; i < 4; i++) expBits.push_back(node[i]);
      for (int i = 0; i < int'(len); i++) expBits.push_back(pay[i]);
   endtask

   // Checks the wire from the first bit (already showing) for up to stopAt bits.
   task automatic checkBits(input string tag, input int stopAt);
      int n;
      n = expBits.size();
      for (int i = 0; i < n && i < stopAt; i++) begin
         if (i > 0) step();
         checkOutput($sformatf("%s bit%0d", tag, i), 32'(tag_data_o), 32'(expBits[i]));
         checkOutput($sformatf("%s done%0d", tag, i), 32'(done_o), 32'(i == n - 1));
         checkOutput($sformatf("%s busy%0d", tag, i), 32'(ready_o), 32'd0);
      end
   endtask

   task automatic finishPacket(input string tag);
      step();
      checkOutput({tag, " gap tag"}, 32'(tag_data_o), 32'd0);
      checkOutput({tag, " gap ready"}, 32'(ready_o), 32'd0);
      checkOutput({tag, " gap done"}, 32'(done_o), 32'd0);
      step();
      checkOutput({tag, " idle tag"}, 32'(tag_data_o), 32'd0);
      checkOutput({tag, " idle ready"}, 32'(ready_o), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n_i = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 15'h0);

      // Reset holds everything quiet, ready included.
      for (int k = 0; k < 2; k++) begin
         step();
         checkOutput("reset tag", 32'(tag_data_o), 32'd0);
         checkOutput("reset done", 32'(done_o), 32'd0);
         checkOutput("reset ready", 32'(ready_o), 32'd0);
      end
      reset_n_i = 1'b1;
      #1;
      checkOutput("ready before edge", 32'(ready_o), 32'd0);
      step();
      checkOutput("ready after edge", 32'(ready_o), 32'd1);
      checkOutput("idle tag", 32'(tag_data_o), 32'd0);

      // Init sequence: 64 ones, 16 zeros, done on the 80th cycle, straight back to IDLE.
      expBits.delete();
      for (int i = 0; i < 64; i++) expBits.push_back(1'b1);
      for (int i = 0; i < 16; i++) expBits.push_back(1'b0);
      applyStimulus(1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 15'h0);
      step();
      applyStimulus(1'b0, 1'b0, 4'hF, 1'b1, 4'hF, 15'h7FFF);
      checkBits("init", 1000);
      step();
      checkOutput("init ready", 32'(ready_o), 32'd1);
      checkOutput("init idle tag", 32'(tag_data_o), 32'd0);
      checkOutput("init rx", 32'(rxInit), 32'd1);

      // node=3 dnr=1 len=2 payload=2'b10, hand-computed wire image.
      expBits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      applyStimulus(1'b1, 1'b0, 4'd3, 1'b1, 4'd2, 15'b10);
      step();
      applyStimulus(1'b0, 1'b1, 4'hC, 1'b0, 4'h9, 15'h7FFF);
      checkBits("pkt3", 1000);
      finishPacket("pkt3");

      // len=0: no payload, done on the last node bit.
      expBits = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      applyStimulus(1'b1, 1'b0, 4'd15, 1'b0, 4'd0, 15'h7FFF);
      step();
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 15'h0);
      checkBits("len0", 1000);
      finishPacket("len0");

      // Back-to-back with v_i held high; inputs switch to packet B right after A is accepted.
      buildBits(4'd3, 1'b1, 4'd9, 15'b101);
      applyStimulus(1'b1, 1'b0, 4'd9, 1'b1, 4'd3, 15'b101);
      step();
      applyStimulus(1'b1, 1'b0, 4'd6, 1'b0, 4'd5, 15'h13);
      checkBits("b2bA", 1000);
      finishPacket("b2bA");
      buildBits(4'd5, 1'b0, 4'd6, 15'h13);
      step();
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 15'h0);
      checkBits("b2bB", 1000);
      finishPacket("b2bB");
      checkOutput("b2bB rx node", 32'(rxNode), 32'd6);
      checkOutput("b2bB rx len", 32'(rxLen), 32'd5);

      // Abort a len=15 packet mid-payload with an asynchronous reset.
      buildBits(4'd15, 1'b1, 4'd5, 15'h5A5A);
      applyStimulus(1'b1, 1'b0, 4'd5, 1'b1, 4'd15, 15'h5A5A);
      step();
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 15'h0);
      checkBits("abort", 14);
      #2;
      reset_n_i = 1'b0;
      #1;
      checkOutput("abort async tag", 32'(tag_data_o), 32'd0);
      checkOutput("abort ready", 32'(ready_o), 32'd0);
      checkOutput("abort done", 32'(done_o), 32'd0);
      step();
      reset_n_i = 1'b1;
      step();
      checkOutput("abort ready back", 32'(ready_o), 32'd1);

      // Re-initialise the receiver, then a packet must decode through the model.
      expBits.delete();
      for (int i = 0; i < 64; i++) expBits.push_back(1'b1);
      for (int i = 0; i < 16; i++) expBits.push_back(1'b0);
      applyStimulus(1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 15'h0);
      step();
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 15'h0);
      checkBits("reinit", 1000);
      step();
      rxBefore = rxPackets;
      buildBits(4'd7, 1'b1, 4'd12, 15'h2B3C);
      applyStimulus(1'b1, 1'b0, 4'd12, 1'b1, 4'd7, 15'h2B3C);
      step();
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 15'h0);
      checkBits("loop", 1000);
      finishPacket("loop");
      checkOutput("loop rx count", 32'(rxPackets - rxBefore), 32'd1);
      checkOutput("loop rx node", 32'(rxNode), 32'd12);
      checkOutput("loop rx dnr", 32'(rxDnr), 32'd1);
      checkOutput("loop rx len", 32'(rxLen), 32'd7);
      checkOutput("loop rx payload", 32'(rxPay), 32'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
